// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable, counters, syncs, blanking and frame
// strobes as seen by every raster consumer.
interface vga_timing_gen_if #(
    parameter int H_WIDTH = 10,
    parameter int V_WIDTH = 10,
    parameter int FRAME_W = 8
);
    logic               pix_en;
    logic [H_WIDTH-1:0] hpos;
    logic [V_WIDTH-1:0] vpos;
    logic               hsync;
    logic               vsync;
    logic               hblank;
    logic               vblank;
    logic               visible;
    logic               line_end;
    logic               frame_end;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        output pix_en, hpos, vpos, hsync, vsync, hblank, vblank,
               visible, line_end, frame_end, frame_count
    );

    modport slave (
        input  pix_en, hpos, vpos, hsync, vsync, hblank, vblank,
               visible, line_end, frame_end, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel clock-enable divider,
// pixel/line counters, registered sync pulses, blanking flags and a
// completed-frame counter.
module vga_timing_gen #(
    parameter int H_VIEW       = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VIEW       = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int H_WIDTH      = 10,
    parameter int V_WIDTH      = 10,
    parameter int HSYNC_ACTIVE = 1,
    parameter int VSYNC_ACTIVE = 1,
    parameter int CLK_DIV      = 1,
    parameter int FRAME_W      = 8
) (
    input  logic           clk,
    input  logic           reset,
    vga_timing_gen_if.master o_vga
);
    localparam int H_MAX        = H_VIEW + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX        = V_VIEW + V_FRONT + V_SYNC + V_BACK - 1;
    localparam int H_SYNC_START = H_VIEW + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VIEW + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [H_WIDTH-1:0] H_MAX_L    = H_WIDTH'(H_MAX);
    localparam logic [H_WIDTH-1:0] H_VIEW_L   = H_WIDTH'(H_VIEW);
    localparam logic [H_WIDTH-1:0] H_SS_PRE_L = H_WIDTH'(H_SYNC_START - 1);
    localparam logic [H_WIDTH-1:0] H_SE_PRE_L = H_WIDTH'(H_SYNC_END - 1);
    localparam logic [V_WIDTH-1:0] V_MAX_L    = V_WIDTH'(V_MAX);
    localparam logic [V_WIDTH-1:0] V_VIEW_L   = V_WIDTH'(V_VIEW);
    localparam logic [V_WIDTH-1:0] V_SS_PRE_L = V_WIDTH'(V_SYNC_START - 1);
    localparam logic [V_WIDTH-1:0] V_SE_PRE_L = V_WIDTH'(V_SYNC_END - 1);

    // Sync registers hold the pin level directly, so polarity never passes
    // through combinational logic on the way out.
    localparam logic HS_ON  = (HSYNC_ACTIVE != 0);
    localparam logic HS_OFF = !HS_ON;
    localparam logic VS_ON  = (VSYNC_ACTIVE != 0);
    localparam logic VS_OFF = !VS_ON;

    logic               w_pix_en;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_line_end;
    logic               w_frame_end;
    logic [H_WIDTH-1:0] r_hpos;
    logic [V_WIDTH-1:0] r_vpos;
    logic               r_hsync;
    logic               r_vsync;
    logic [FRAME_W-1:0] r_frame_count;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] r_div;

            // Pixel divider: counts 0..CLK_DIV-1, enable on the last count
            always_ff @(posedge clk) begin
                if (reset)
                    r_div <= '0;
                else if (r_div == DIV_LAST)
                    r_div <= '0;
                else
                    r_div <= r_div + 1'b1;
            end

            assign w_pix_en = (r_div == DIV_LAST);
        end else begin : g_nodiv
            assign w_pix_en = 1'b1;
        end
    endgenerate

    assign w_h_last    = (r_hpos == H_MAX_L);
    assign w_v_last    = (r_vpos == V_MAX_L);
    assign w_line_end  = w_pix_en && w_h_last;
    assign w_frame_end = w_line_end && w_v_last;

    // Pixel and line counters advance on pixel ticks, lines on the last pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (w_pix_en) begin
            r_hpos <= w_h_last ? '0 : r_hpos + 1'b1;
            if (w_h_last)
                r_vpos <= w_v_last ? '0 : r_vpos + 1'b1;
        end
    end

    // hsync switches one pixel early so it lines up with hpos after the tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= HS_OFF;
        end else if (w_pix_en) begin
            if (r_hpos == H_SS_PRE_L)
                r_hsync <= HS_ON;
            else if (r_hpos == H_SE_PRE_L)
                r_hsync <= HS_OFF;
        end
    end

    // vsync switches on the line_end tick, the same edge vpos moves
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync <= VS_OFF;
        end else if (w_line_end) begin
            if (r_vpos == V_SS_PRE_L)
                r_vsync <= VS_ON;
            else if (r_vpos == V_SE_PRE_L)
                r_vsync <= VS_OFF;
        end
    end

    // Completed-frame counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (reset)
            r_frame_count <= '0;
        else if (w_frame_end)
            r_frame_count <= r_frame_count + 1'b1;
    end

    assign o_vga.pix_en      = w_pix_en;
    assign o_vga.hpos        = r_hpos;
    assign o_vga.vpos        = r_vpos;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.hblank      = (r_hpos >= H_VIEW_L);
    assign o_vga.vblank      = (r_vpos >= V_VIEW_L);
    assign o_vga.visible     = (r_hpos < H_VIEW_L) && (r_vpos < V_VIEW_L);
    assign o_vga.line_end    = w_line_end;
    assign o_vga.frame_end   = w_frame_end;
    assign o_vga.frame_count = r_frame_count;
endmodule
